// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin two-port arbiter issuing one SDRAM command at a time with timeout abort
module sdram_arbiter #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_done0,
    output logic              o_done1,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic              o_sdram_write,
    output logic              o_sdram_read,
    output logic [ADDR_W-1:0] o_sdram_addr,
    output logic [DATA_W-1:0] o_sdram_wdata,
    input  logic [DATA_W-1:0] i_sdram_data,
    input  logic              i_sdram_valid
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    state_t          r_state;
    logic            r_last;
    logic            r_owner;
    logic [CW-1:0]   r_cnt;
    logic            w_win;
    logic            w_we;
    // Requester 1 wins unless requester 0 also asks and 1 was served last
    assign w_win  = i_req1 & ~(i_req0 & r_last);
    assign w_we   = w_win ? i_we1 : i_we0;
    assign o_busy = r_state != IDLE;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_last        <= 1'b1;
            r_owner       <= 1'b0;
            r_cnt         <= '0;
            o_gnt0        <= 1'b0;
            o_gnt1        <= 1'b0;
            o_done0       <= 1'b0;
            o_done1       <= 1'b0;
            o_err         <= 1'b0;
            o_rdata       <= '0;
            o_sdram_write <= 1'b0;
            o_sdram_read  <= 1'b0;
            o_sdram_addr  <= '0;
            o_sdram_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_req0 | i_req1) begin
                    r_state       <= ISSUE;
                    r_owner       <= w_win;
                    r_last        <= w_win;
                    r_cnt         <= '0;
                    o_gnt0        <= ~w_win;
                    o_gnt1        <= w_win;
                    o_sdram_write <= w_we;
                    o_sdram_read  <= ~w_we;
                    o_sdram_addr  <= w_win ? i_addr1 : i_addr0;
                    o_sdram_wdata <= w_win ? i_wdata1 : i_wdata0;
                end
                ISSUE: begin
                    o_gnt0 <= 1'b0;
                    o_gnt1 <= 1'b0;
                    // A valid on the final counted cycle still completes normally
                    if (i_sdram_valid || r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state       <= DONE;
                        o_err         <= ~i_sdram_valid;
                        o_done0       <= ~r_owner;
                        o_done1       <= r_owner;
                        o_sdram_write <= 1'b0;
                        o_sdram_read  <= 1'b0;
                        if (i_sdram_valid && o_sdram_read) o_rdata <= i_sdram_data;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    o_done0 <= 1'b0;
                    o_done1 <= 1'b0;
                    o_err   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: table-driven cycle vectors plus a command-hold sequence for sdram_arbiter
module tb_sdram_arbiter;
    logic        clk = 0, rst = 1;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, vld = 0;
    logic [25:0] addr0 = 26'h123, addr1 = 26'h123;
    logic [15:0] wdata0 = 16'hBEEF, wdata1 = 16'h4321, sdata = 0;
    logic        gnt0, gnt1, done0, done1, err, busy, swr, srd;
    logic [15:0] rdata, swdata;
    logic [25:0] saddr;
    int checks = 0, errors = 0;

    sdram_arbiter #(.ADDR_W(26), .DATA_W(16), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1), .o_err(err),
        .o_rdata(rdata), .o_busy(busy), .o_sdram_write(swr), .o_sdram_read(srd),
        .o_sdram_addr(saddr), .o_sdram_wdata(swdata), .i_sdram_data(sdata), .i_sdram_valid(vld));

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, r0, r1, w0, w1, v;
        logic [15:0] sd;
        logic [7:0]  eo;
        logic [15:0] erd;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, a, b, c, d, v, input logic [15:0] sd,
                       input logic [7:0] eo, input logic [15:0] erd);
        tbl.push_back('{r, a, b, c, d, v, sd, eo, erd});
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs;
        return {gnt0, gnt1, done0, done1, err, busy, swr, srd};
    endfunction

    initial begin
        bit got;
        // order: gnt0 gnt1 done0 done1 err busy write read
        add(1,0,0,0,0,0,0, 8'b00000000, 0);
        add(0,1,0,1,0,0,0, 8'b10000110, 0);
        for (int k = 0; k < 4; k++) add(0,0,0,1,0,0,0, 8'b00000110, 0);
        add(0,0,0,1,0,1,0, 8'b00100100, 0);
        add(0,0,0,0,0,0,0, 8'b00000000, 0);
        add(0,0,0,0,0,1,16'h5555, 8'b00000000, 0);
        add(0,0,1,0,0,0,0, 8'b01000101, 0);
        add(0,0,0,0,0,1,16'hBEEF, 8'b00010100, 16'hBEEF);
        add(0,0,0,0,0,0,0, 8'b00000000, 16'hBEEF);
        add(0,1,1,1,0,0,0, 8'b10000110, 16'hBEEF);
        add(0,1,1,1,0,1,16'h9999, 8'b00100100, 16'hBEEF);
        add(0,1,1,1,0,0,0, 8'b00000000, 16'hBEEF);
        add(0,1,1,1,0,0,0, 8'b01000101, 16'hBEEF);
        add(0,1,1,1,0,1,16'h0F0F, 8'b00010100, 16'h0F0F);
        add(0,1,1,1,0,0,0, 8'b00000000, 16'h0F0F);
        add(0,1,1,1,0,0,0, 8'b10000110, 16'h0F0F);
        add(0,1,1,1,0,1,0, 8'b00100100, 16'h0F0F);
        add(0,1,1,1,0,0,0, 8'b00000000, 16'h0F0F);
        add(0,1,1,1,0,0,0, 8'b01000101, 16'h0F0F);
        add(0,1,1,1,0,1,16'hA5A5, 8'b00010100, 16'hA5A5);
        add(0,0,0,0,0,0,0, 8'b00000000, 16'hA5A5);
        add(0,1,0,1,0,0,0, 8'b10000110, 16'hA5A5);
        for (int k = 0; k < 7; k++) add(0,0,0,1,0,0,16'h1234, 8'b00000110, 16'hA5A5);
        add(0,0,0,1,0,0,0, 8'b00101100, 16'hA5A5);
        add(0,0,0,0,0,0,0, 8'b00000000, 16'hA5A5);
        add(0,1,0,1,0,0,0, 8'b10000110, 16'hA5A5);
        for (int k = 0; k < 7; k++) add(0,0,0,1,0,0,0, 8'b00000110, 16'hA5A5);
        add(0,0,0,1,0,1,0, 8'b00100100, 16'hA5A5);
        add(0,0,0,0,0,0,0, 8'b00000000, 16'hA5A5);
        add(0,1,0,0,0,0,0, 8'b10000101, 16'hA5A5);
        add(0,0,0,0,0,0,0, 8'b00000101, 16'hA5A5);
        add(1,0,0,0,0,0,0, 8'b00000000, 0);
        add(0,0,0,0,0,1,16'h7777, 8'b00000000, 0);
        add(0,1,1,1,0,0,0, 8'b10000110, 0);
        add(0,0,0,1,0,1,0, 8'b00100100, 0);
        add(0,0,0,0,0,0,0, 8'b00000000, 0);

        step;
        check("reset_cmd_regs", {saddr, swdata, rdata}, 58'h0);
        foreach (tbl[i]) begin
            {rst, req0, req1, we0, we1, vld} = {tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1, tbl[i].v};
            sdata = tbl[i].sd;
            step;
            check($sformatf("row%0d_out", i), outs(), tbl[i].eo);
            check($sformatf("row%0d_rdata", i), rdata, tbl[i].erd);
            if (tbl[i].eo[1] || tbl[i].eo[0]) check($sformatf("row%0d_addr", i), saddr, 26'h123);
            if (tbl[i].eo[1]) check($sformatf("row%0d_wdata", i), swdata, 16'hBEEF);
        end

        {rst, vld, sdata} = '0;
        {req1, we1, addr1, wdata1} = {1'b1, 1'b1, 26'h3FFFFFF, 16'h1234};
        step;
        check("hold_gnt1", outs(), 8'b01000110);
        check("hold_cmd0", {saddr, swdata}, {26'h3FFFFFF, 16'h1234});
        {req1, we1, addr1, wdata1} = '0;
        for (int k = 0; k < 3; k++) begin
            step;
            check($sformatf("hold_out%0d", k), outs(), 8'b00000110);
            check($sformatf("hold_cmd%0d", k + 1), {saddr, swdata}, {26'h3FFFFFF, 16'h1234});
        end
        vld = 1;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            step;
            vld = 0;
            got = done1;
        end
        check("hold_done1_seen", got, 1'b1);
        check("hold_err", err, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): ADDR_W, 26, SDRAM word address width; DATA_W, 16, data width; TIMEOUT, 1023, max ISSUE cycles before abort (>=2).
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- i_clk, in, 1, single clock; all logic rising-edge.
- i_rst, in, 1, synchronous active-high reset.
- i_req0 / i_req1, in, 1, level request from requester 0 / 1.
- i_we0 / i_we1, in, 1, 1 = write, 0 = read.
- i_addr0 / i_addr1, in, ADDR_W, request address.
- i_wdata0 / i_wdata1, in, DATA_W, write data.
- o_gnt0 / o_gnt1, out, 1, one-cycle pulse: request captured.
- o_done0 / o_done1, out, 1, one-cycle pulse: transaction finished.
- o_err, out, 1, qualifies o_doneN: 1 = timed out.
- o_rdata, out, DATA_W, read data; valid with o_doneN of a read.
- o_busy, out, 1, high in any state other than IDLE.
- o_sdram_write / o_sdram_read, out, 1, command strobes to the SDRAM wrapper.
- o_sdram_addr, out, ADDR_W, wrapper address.
- o_sdram_wdata, out, DATA_W, wrapper write data.
- i_sdram_data, in, DATA_W, wrapper read data.
- i_sdram_valid, in, 1, wrapper completion pulse for read or write.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE and DONE; only one transaction outstanding at any time.
REQ-004 In IDLE, if any i_reqN is high at a clock edge, the arbiter SHALL select a winner, latch its we/addr/wdata into command registers and enter ISSUE at that edge.
REQ-005 Tie-break SHALL be round-robin: with both requests high, the requester not served last wins; the pointer updates on every grant.
REQ-006 o_gntN SHALL pulse high for exactly the first ISSUE cycle, for the winner only.
REQ-007 In ISSUE, exactly one of o_sdram_write / o_sdram_read SHALL be high, per the latched we, with o_sdram_addr / o_sdram_wdata held constant from the latched registers.
REQ-008 In ISSUE, i_sdram_valid=1 SHALL cause a transition to DONE, o_err=0; for reads, i_sdram_data SHALL be captured into o_rdata at that edge.
REQ-009 An ISSUE cycle counter SHALL start at 0; when it reaches TIMEOUT-1 without valid, the FSM SHALL enter DONE with o_err=1 and o_rdata unchanged.
REQ-010 If valid coincides with the timeout cycle, valid SHALL win (o_err=0).
REQ-011 Both command strobes SHALL be low in IDLE and DONE, giving at least one low cycle between consecutive commands.
REQ-012 In DONE, o_doneN SHALL pulse for the served requester for one cycle, o_err held alongside; the next state SHALL be IDLE.
REQ-013 Minimum transaction latency SHALL be 3 cycles from request sample to o_done (req edge -> ISSUE, valid same cycle -> DONE); throughput SHALL be at most one transaction per 3 cycles.
REQ-014 i_sdram_valid outside ISSUE SHALL be ignored, with no state or output change.
REQ-015 Requests SHALL be level-sensitive; a request still high in IDLE after DONE is a new transaction. Requesters drop or update req after o_gnt.
REQ-016 Input changes on the served requester after o_gnt SHALL NOT affect the in-flight command.
REQ-017 o_rdata SHALL hold its last captured value until the next successful read.

Reset
REQ-018 With i_rst high at an edge, the block SHALL go to IDLE, zero the counter and set the round-robin pointer to "last served = 1", so requester 0 wins the first tie.
REQ-019 The same reset edge SHALL drive all strobes, o_gntN, o_doneN, o_err and o_busy to 0, and zero o_rdata, o_sdram_addr and o_sdram_wdata.
REQ-020 Reset during ISSUE SHALL abort silently: strobes low the following cycle, no o_done; a later i_sdram_valid is ignored per REQ-014.

Verification
REQ-021 Single write: req0, we0=1, addr0=0x0000123, wdata0=0xBEEF; valid 4 cycles into ISSUE -> gnt0 pulse, o_sdram_write high for 5 cycles with addr 0x0000123 / data 0xBEEF, then done0 with err=0.
REQ-022 Read-back: req1, we1=0, addr1=0x0000123; wrapper returns 0xBEEF with valid -> done1, o_rdata=0xBEEF, o_sdram_read never coincident with o_sdram_write.
REQ-023 Contention: req0 and req1 held high continuously from reset -> grant order 0,1,0,1, one strobe-low cycle between commands, each done matched to its gnt.
REQ-024 Timeout: TIMEOUT=8, no valid -> strobe high exactly 8 cycles, done0 with err=1, o_rdata unchanged; valid on cycle 8 instead -> err=0.
REQ-025 Reset mid-ISSUE: assert i_rst in cycle 2 of a read -> next cycle strobes 0, busy 0, no done; stray valid afterward is ignored; next tie goes to requester 0.
